// File: rtl/bus_frame_receiver.sv
`default_nettype none
// ============================================================================
// bus_frame_receiver : turns header + ADDRW/8 address byte frames into one
// command, waits for completion, returns a one-hot ack. Option: BUS_PARITY_EN
// Rev 1.0
// ============================================================================
module bus_frame_receiver #(
  parameter int ADDRW = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             bus_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_src,
  output logic [1:0]       cmd_op,
  output logic [ADDRW-1:0] cmd_addr,
  input  logic             done_in,
  output logic [2:0]       ack_out,
  output logic             err_out
);

  localparam int ABYTES = ADDRW / 8;
  localparam int CW     = (ABYTES > 1) ? $clog2(ABYTES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ABYTES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       src_q, src_d;
  logic [1:0]       op_q, op_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             par_bad_q, par_bad_d;
  logic             bus_ready_q, cmd_valid_q;
  logic             err_q, err_d;
  logic [2:0]       ack_q, ack_d;
  logic             w_accept;
  logic             w_hdr_par_bad;

  assign w_accept = data_valid && bus_ready_q;

`ifdef BUS_PARITY_EN
  // Even parity over the whole header byte: any odd XOR is a bad header.
  assign w_hdr_par_bad = ^data_in;
`else
  assign w_hdr_par_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    op_d      = op_q;
    addr_d    = addr_q;
    par_bad_d = par_bad_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          src_d     = data_in[7:6];
          op_d      = data_in[5:4];
          par_bad_d = w_hdr_par_bad;
          cnt_d     = '0;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (w_accept) begin
          addr_d = (addr_q << 8) | ADDRW'(data_in);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            cnt_d = '0;
            // Bad source and bad parity share one error pulse.
            if ((src_q == 2'b00) || par_bad_q) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      ISSUE:     if (cmd_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (done_in)   state_d = ACK;
      ACK:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    ack_d = (state_d == ACK) ? (3'b001 << (src_q - 2'd1)) : 3'b000;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src_q       <= 2'b00;
      op_q        <= 2'b00;
      addr_q      <= '0;
      par_bad_q   <= 1'b0;
      bus_ready_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      par_bad_q   <= par_bad_d;
      bus_ready_q <= (state_d == IDLE) || (state_d == ADDR);
      cmd_valid_q <= (state_d == ISSUE);
      err_q       <= err_d;
      ack_q       <= ack_d;
    end
  end

  assign bus_ready = bus_ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_src   = src_q;
  assign cmd_op    = op_q;
  assign cmd_addr  = addr_q;
  assign ack_out   = ack_q;
  assign err_out   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_frame_receiver.sv
`default_nettype none
// Directed bench for bus_frame_receiver (ADDRW=24).
module tb_bus_frame_receiver;

  localparam int ADDRW = 24;
`ifdef BUS_PARITY_EN
  localparam logic [7:0] SHA_HDR = 8'h81;
`else
  localparam logic [7:0] SHA_HDR = 8'h80;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             bus_ready;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_src;
  logic [1:0]       cmd_op;
  logic [ADDRW-1:0] cmd_addr;
  logic             done_in;
  logic [2:0]       ack_out;
  logic             err_out;

  int n_vec = 0;
  int n_err = 0;

  bus_frame_receiver #(.ADDRW(ADDRW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .bus_ready (bus_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .done_in   (done_in),
    .ack_out   (ack_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in = 8'h00; data_valid = 1'b0; cmd_ready = 1'b0; done_in = 1'b0;
    tick();
    n_vec++; if (bus_ready !== 1'b0) begin n_err++; $display("FAIL rst_bus_ready: got %b want 0", bus_ready); end
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
    n_vec++; if (ack_out !== 3'b000) begin n_err++; $display("FAIL rst_ack: got %b want 000", ack_out); end
    n_vec++; if (err_out !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_out); end
    tick();
    n_vec++; if (bus_ready !== 1'b0) begin n_err++; $display("FAIL rst_bus_ready2: got %b want 0", bus_ready); end
    rst = 1'b0;
    tick();
    n_vec++; if (bus_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_bus_ready: got %b want 1", bus_ready); end
    n_vec++; if (cmd_addr !== 24'h0 || cmd_src !== 2'b00 || cmd_op !== 2'b00) begin
      n_err++; $display("FAIL rst_cmd_fields: got src=%b op=%b addr=%h want 0/0/0", cmd_src, cmd_op, cmd_addr); end
  endtask

  task automatic test_aes();
    cmd_ready = 1'b1;
    send_byte(8'h50); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    n_vec++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL aes_cmd_valid: got %b want 1", cmd_valid); end
    n_vec++; if (cmd_src !== 2'b01 || cmd_op !== 2'b01) begin n_err++; $display("FAIL aes_src_op: got %b/%b want 01/01", cmd_src, cmd_op); end
    n_vec++; if (cmd_addr !== 24'h123456) begin n_err++; $display("FAIL aes_addr: got %h want 123456", cmd_addr); end
    n_vec++; if (bus_ready !== 1'b0) begin n_err++; $display("FAIL aes_bus_ready_issue: got %b want 0", bus_ready); end
    tick();
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL aes_cmd_valid_drop: got %b want 0", cmd_valid); end
    cmd_ready = 1'b0;
    tick();
    n_vec++; if (ack_out !== 3'b000) begin n_err++; $display("FAIL aes_early_ack: got %b want 000", ack_out); end
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_vec++; if (ack_out !== 3'b001) begin n_err++; $display("FAIL aes_ack: got %b want 001", ack_out); end
    tick();
    n_vec++; if (ack_out !== 3'b000) begin n_err++; $display("FAIL aes_ack_len: got %b want 000", ack_out); end
    n_vec++; if (bus_ready !== 1'b1) begin n_err++; $display("FAIL aes_ready_after: got %b want 1", bus_ready); end
  endtask

  task automatic test_sha_backpressure();
    cmd_ready = 1'b0;
    send_byte(SHA_HDR); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (cmd_valid !== 1'b1 || cmd_addr !== 24'hAABBCC || cmd_src !== 2'b10 || bus_ready !== 1'b0) begin
        n_err++; $display("FAIL sha_hold[%0d]: got v=%b addr=%h src=%b rdy=%b want 1/aabbcc/10/0", i, cmd_valid, cmd_addr, cmd_src, bus_ready); end
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL sha_cmd_drop: got %b want 0", cmd_valid); end
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_vec++; if (ack_out !== 3'b010) begin n_err++; $display("FAIL sha_ack: got %b want 010", ack_out); end
    tick();
    n_vec++; if (ack_out !== 3'b000) begin n_err++; $display("FAIL sha_ack_len: got %b want 000", ack_out); end
  endtask

  task automatic test_invalid_src();
    cmd_ready = 1'b1;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    n_vec++; if (err_out !== 1'b1) begin n_err++; $display("FAIL inv_err: got %b want 1", err_out); end
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL inv_cmd_valid: got %b want 0", cmd_valid); end
    tick();
    n_vec++; if (err_out !== 1'b0) begin n_err++; $display("FAIL inv_err_len: got %b want 0", err_out); end
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (cmd_valid !== 1'b0 || ack_out !== 3'b000) begin
        n_err++; $display("FAIL inv_quiet[%0d]: got v=%b ack=%b want 0/000", i, cmd_valid, ack_out); end
      tick();
    end
    send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    n_vec++; if (cmd_valid !== 1'b1 || cmd_src !== 2'b11 || cmd_addr !== 24'h000007) begin
      n_err++; $display("FAIL inv_next_frame: got v=%b src=%b addr=%h want 1/11/000007", cmd_valid, cmd_src, cmd_addr); end
    tick();
    cmd_ready = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_vec++; if (ack_out !== 3'b100) begin n_err++; $display("FAIL inv_next_ack: got %b want 100", ack_out); end
    tick();
  endtask

  task automatic test_gaps_stray();
    logic [7:0] abytes [3];
    abytes[0] = 8'h9A; abytes[1] = 8'hBC; abytes[2] = 8'hDE;
    cmd_ready = 1'b0;
    send_byte(8'h60);
    for (int b = 0; b < 3; b++) begin
      done_in = 1'b1;
      tick(); tick(); tick();
      n_vec++; if (ack_out !== 3'b000 || cmd_valid !== 1'b0 || bus_ready !== 1'b1) begin
        n_err++; $display("FAIL gap[%0d]: got ack=%b v=%b rdy=%b want 000/0/1", b, ack_out, cmd_valid, bus_ready); end
      send_byte(abytes[b]);
    end
    n_vec++; if (cmd_valid !== 1'b1 || cmd_addr !== 24'h9ABCDE || cmd_op !== 2'b10) begin
      n_err++; $display("FAIL gap_cmd: got v=%b addr=%h op=%b want 1/9abcde/10", cmd_valid, cmd_addr, cmd_op); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (ack_out !== 3'b000 || cmd_valid !== 1'b1) begin
        n_err++; $display("FAIL gap_issue_done[%0d]: got ack=%b v=%b want 000/1", i, ack_out, cmd_valid); end
    end
    cmd_ready = 1'b1;
    tick();
    n_vec++; if (ack_out !== 3'b000 || cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL gap_handshake_done: got ack=%b v=%b want 000/0", ack_out, cmd_valid); end
    cmd_ready = 1'b0; done_in = 1'b0;
    tick();
    n_vec++; if (ack_out !== 3'b000) begin n_err++; $display("FAIL gap_done_forgotten: got %b want 000", ack_out); end
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_vec++; if (ack_out !== 3'b001) begin n_err++; $display("FAIL gap_ack: got %b want 001", ack_out); end
    tick();
  endtask

  task automatic test_reset_midframe();
    cmd_ready = 1'b1;
    send_byte(8'h40); send_byte(8'h11);
    rst = 1'b1;
    tick();
    n_vec++; if (bus_ready !== 1'b0 || cmd_valid !== 1'b0 || cmd_addr !== 24'h0) begin
      n_err++; $display("FAIL mid_rst: got rdy=%b v=%b addr=%h want 0/0/000000", bus_ready, cmd_valid, cmd_addr); end
    rst = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (bus_ready !== 1'b1 || cmd_valid !== 1'b0 || ack_out !== 3'b000) begin
      n_err++; $display("FAIL mid_rst_after: got rdy=%b v=%b ack=%b want 1/0/000", bus_ready, cmd_valid, ack_out); end
    send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    n_vec++; if (cmd_valid !== 1'b1 || cmd_src !== 2'b11 || cmd_addr !== 24'h000001) begin
      n_err++; $display("FAIL mid_ctrl_cmd: got v=%b src=%b addr=%h want 1/11/000001", cmd_valid, cmd_src, cmd_addr); end
    tick();
    cmd_ready = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_vec++; if (ack_out !== 3'b100) begin n_err++; $display("FAIL mid_ctrl_ack: got %b want 100", ack_out); end
    tick();
    n_vec++; if (ack_out !== 3'b000 || bus_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_ctrl_end: got ack=%b rdy=%b want 000/1", ack_out, bus_ready); end
  endtask

`ifdef BUS_PARITY_EN
  task automatic test_parity();
    cmd_ready = 1'b1;
    send_byte(8'h51); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    n_vec++; if (err_out !== 1'b1 || cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL par_bad: got err=%b v=%b want 1/0", err_out, cmd_valid); end
    tick();
    n_vec++; if (err_out !== 1'b0 || cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL par_bad_after: got err=%b v=%b want 0/0", err_out, cmd_valid); end
    send_byte(8'h50); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    n_vec++; if (cmd_valid !== 1'b1 || err_out !== 1'b0 || cmd_addr !== 24'h010203) begin
      n_err++; $display("FAIL par_good: got v=%b err=%b addr=%h want 1/0/010203", cmd_valid, err_out, cmd_addr); end
    tick();
    cmd_ready = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_vec++; if (ack_out !== 3'b001) begin n_err++; $display("FAIL par_good_ack: got %b want 001", ack_out); end
    tick();
  endtask
`else
  task automatic test_reserved_bits();
    cmd_ready = 1'b1;
    send_byte(8'h5E); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    n_vec++; if (cmd_valid !== 1'b1 || err_out !== 1'b0 || cmd_op !== 2'b01 || cmd_addr !== 24'h010203) begin
      n_err++; $display("FAIL rsvd_ignored: got v=%b err=%b op=%b addr=%h want 1/0/01/010203", cmd_valid, err_out, cmd_op, cmd_addr); end
    tick();
    cmd_ready = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_vec++; if (ack_out !== 3'b001) begin n_err++; $display("FAIL rsvd_ack: got %b want 001", ack_out); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_aes();
    test_sha_backpressure();
    test_invalid_src();
    test_gaps_stray();
    test_reset_midframe();
`ifdef BUS_PARITY_EN
    test_parity();
`else
    test_reserved_bits();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
